// File: rtl/joy_db15_pkg.sv
// Shared constants and state encoding for the DB15 joystick serial responder.
package joy_db15_pkg;

    localparam int PW         = 16;
    localparam int FRAME_BITS = 2 * PW;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Bit positions within a player word
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_D     = 7;
    localparam int BTN_E     = 8;
    localparam int BTN_F     = 9;

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Two-flop synchronizer with rising-edge detect for one host strobe.
// Defining JOY_DB15_TX_DEGLITCH_EN adds a 3-sample majority filter after the synchronizer.
module joy_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= {2{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

`ifdef JOY_DB15_TX_DEGLITCH_EN
    logic [2:0] win_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_reg <= {3{RST_VAL}};
        end else begin
            win_reg <= {win_reg[1:0], sync_reg[1]};
        end
    end

    // Two of three samples must agree, so a single-cycle pulse never passes
    assign level = (win_reg[0] & win_reg[1]) | (win_reg[0] & win_reg[2]) |
                   (win_reg[1] & win_reg[2]);
`else
    assign level = sync_reg[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= RST_VAL;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick device-side responder: parallel load of two player words, serial shift-out.
// Optional input deglitching via JOY_DB15_TX_DEGLITCH_EN (see joy_sync_edge).
module joy_db15_tx
    import joy_db15_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] joystick1,
    input  logic [PW-1:0] joystick2,
    input  logic          JOY_CLK,
    input  logic          JOY_LOAD,
    output logic          JOY_DATA,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    logic clk_level_unused;
    logic clk_rise;
    logic load_s;
    logic load_rise;

    joy_sync_edge #(.RST_VAL(1'b0)) u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (JOY_CLK),
        .level (clk_level_unused),
        .rise  (clk_rise)
    );

    // Load strobe idles high; resetting its chain high avoids a spurious load
    joy_sync_edge #(.RST_VAL(1'b1)) u_load_sync (
        .clk   (clk),
        .reset (reset),
        .din   (JOY_LOAD),
        .level (load_s),
        .rise  (load_rise)
    );

    state_t                state_reg, state_next;
    logic [FRAME_BITS-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  data_reg, data_next;
    logic                  ovr_reg, ovr_next;
    logic                  done_reg, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            shift_reg <= '1;
            cnt_reg   <= '0;
            data_reg  <= 1'b1;
            ovr_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            ovr_reg   <= ovr_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        ovr_next   = ovr_reg;
        done_next  = 1'b0;

        // Load held low wins over everything, including a concurrent shift edge
        if (!load_s) begin
            state_next = ST_LOAD;
            shift_next = ~{joystick2, joystick1};
            data_next  = ~joystick1[0];
            cnt_next   = '0;
            ovr_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    if (load_rise) begin
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shift_next = {1'b1, shift_reg[FRAME_BITS-1:1]};
                        data_next  = shift_reg[1];
                        cnt_next   = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                            data_next  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (clk_rise) begin
                        ovr_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign JOY_DATA   = data_reg;
    assign busy       = (state_reg == ST_SHIFT);
    assign frame_done = done_reg;
    assign overrun    = ovr_reg;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: random frames against a bit-list reference of the wire protocol.
module tb_joy_db15_tx;

`ifdef JOY_DB15_TX_DEGLITCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    joy_db15_tx dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic old_d;
        logic new_d;
        logic busy;
        logic ovr;
    } sb_t;

    sb_t         sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    int          n_edge = 0;
    logic [31:0] cur_word;
    bit          mon_en = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, n_edge, $time);
        end
    endtask

    // Wire bit k of a frame: inverted word bit, idle 1 past the frame end
    function automatic logic wire_bit(input logic [31:0] w, input int k);
        if (k < 32) return ~w[k];
        return 1'b1;
    endfunction

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic load_low(input logic [15:0] a, input logic [15:0] b);
        joystick1 = a;
        joystick2 = b;
        cur_word  = {b, a};
        JOY_LOAD  = 1'b0;
        wait_cyc(8);
        check("load_busy", {31'd0, busy}, 32'd0);
        check("load_data", {31'd0, JOY_DATA}, {31'd0, ~a[0]});
        check("load_overrun", {31'd0, overrun}, 32'd0);
    endtask

    task automatic load_high();
        JOY_LOAD = 1'b1;
        wait_cyc(8);
        n_edge = 0;
        check("shift_busy", {31'd0, busy}, 32'd1);
        check("shift_bit0", {31'd0, JOY_DATA}, {31'd0, wire_bit(cur_word, 0)});
    endtask

    task automatic shift_edge(input int hold);
        sb_t it;
        n_edge++;
        it.old_d = wire_bit(cur_word, n_edge - 1);
        it.new_d = wire_bit(cur_word, n_edge);
        it.busy  = (n_edge < 32);
        it.ovr   = (n_edge > 32);
        if (n_edge == 32) done_exp++;
        sb_q.push_back(it);
        JOY_CLK = 1'b1;
        wait_cyc(hold);
        JOY_CLK = 1'b0;
        wait_cyc(12 - hold);
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input int edges);
        load_low(a, b);
        load_high();
        while (n_edge < edges) shift_edge(4);
        check("frame_done_cnt", done_seen, done_exp);
    endtask

    // Monitor: each host shift edge consumes one scoreboard entry
    initial begin
        sb_t it;
        forever begin
            @(posedge JOY_CLK);
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: edge with no expected entry at t=%0t", $time);
                end else begin
                    it = sb_q.pop_front();
                    repeat (LAT - 1) @(posedge clk);
                    @(negedge clk);
                    check("data_before_lat", {31'd0, JOY_DATA}, {31'd0, it.old_d});
                    @(posedge clk);
                    @(negedge clk);
                    check("data_after_lat", {31'd0, JOY_DATA}, {31'd0, it.new_d});
                    check("busy_after_edge", {31'd0, busy}, {31'd0, it.busy});
                    check("overrun_after_edge", {31'd0, overrun}, {31'd0, it.ovr});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) done_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        JOY_LOAD  = 1'b1;
        JOY_CLK   = 1'b0;
        joystick1 = '0;
        joystick2 = '0;
        cur_word  = '0;
        wait_cyc(4);
        check("rst_data", {31'd0, JOY_DATA}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        wait_cyc(4);

        // Known pattern: only P1 bit0 and P2 bit15 pressed
        run_frame(16'h0001, 16'h8000, 32);

        // Over-clocked frame, then a load must clear overrun
        run_frame(16'($urandom), 16'($urandom), 34);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Abort after 10 shifts
        load_low(16'($urandom), 16'($urandom));
        load_high();
        repeat (10) shift_edge(4);
        load_low(16'($urandom), 16'($urandom));
        check("abort_no_done", done_seen, done_exp);
        load_high();
        while (n_edge < 32) shift_edge(4);
        check("frame_done_cnt", done_seen, done_exp);

        // Shift edge and load fall presented together: load wins
        load_low(16'($urandom), 16'($urandom));
        load_high();
        repeat (5) shift_edge(4);
        mon_en    = 1'b0;
        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
        cur_word  = {joystick2, joystick1};
        JOY_CLK   = 1'b1;
        JOY_LOAD  = 1'b0;
        wait_cyc(8);
        check("simul_busy", {31'd0, busy}, 32'd0);
        check("simul_data", {31'd0, JOY_DATA}, {31'd0, ~joystick1[0]});
        JOY_CLK = 1'b0;
        wait_cyc(4);
        mon_en = 1'b1;
        load_high();
        while (n_edge < 32) shift_edge(4);
        check("frame_done_cnt", done_seen, done_exp);

        // Reset in the middle of a frame
        load_low(16'($urandom), 16'($urandom));
        load_high();
        repeat (17) shift_edge(4);
        reset = 1'b1;
        wait_cyc(1);
        check("midrst_data", {31'd0, JOY_DATA}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_cyc(4);
        mon_en  = 1'b0;
        JOY_CLK = 1'b1;
        wait_cyc(6);
        JOY_CLK = 1'b0;
        wait_cyc(6);
        mon_en = 1'b1;
        check("idle_edge_data", {31'd0, JOY_DATA}, 32'd1);
        check("idle_edge_busy", {31'd0, busy}, 32'd0);
        check("midrst_no_done", done_seen, done_exp);
        run_frame(16'($urandom), 16'($urandom), 32);

        // Short pulse handling, then a 3-cycle pulse shifts exactly once
        load_low(16'($urandom), 16'($urandom));
        load_high();
        repeat (4) shift_edge(4);
`ifdef JOY_DB15_TX_DEGLITCH_EN
        mon_en  = 1'b0;
        JOY_CLK = 1'b1;
        wait_cyc(1);
        JOY_CLK = 1'b0;
        wait_cyc(11);
        mon_en = 1'b1;
        check("glitch_rejected", {31'd0, JOY_DATA}, {31'd0, wire_bit(cur_word, n_edge)});
`else
        shift_edge(1);
`endif
        shift_edge(3);
        while (n_edge < 32) shift_edge(4);
        check("frame_done_cnt", done_seen, done_exp);

        // Random frames
        for (int i = 0; i < 4; i++) begin
            run_frame(16'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1) ? 34 : 32);
        end

        wait_cyc(4);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
